// File: rtl/mode_seq_ctrl.sv
// Sequential mode finder over a 5-sample window. One shared equality comparator walks the
// 10 sample pairs, then a 5-step scan picks the mode. Optional out_cnt port: MODE_SEQ_CNT_OUT_EN.
module mode_seq_ctrl #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_mode,
`ifdef MODE_SEQ_CNT_OUT_EN
    output logic [2:0]    out_cnt,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_CMP,
        S_SEL,
        S_OUT
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] s [5];
    logic [2:0]    c [5];
    logic [2:0]    wr_idx;
    logic [3:0]    p;
    logic [2:0]    k;
    logic [DW-1:0] best_val;
    logic [2:0]    best_cnt;

    logic          accept;
    logic          cmp_en;
    logic          sel_en;
    logic          fin;
    logic [2:0]    pa;
    logic [2:0]    pb;
    logic          pair_eq;
    logic          take_k;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cmp_en    = 1'b0;
        sel_en    = 1'b0;
        fin       = 1'b0;
        if (clear) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        accept = 1'b1;
                        if (wr_idx == 3'd4) state_nxt = S_CMP;
                    end
                end
                S_CMP: begin
                    cmp_en = 1'b1;
                    if (p == 4'd9) state_nxt = S_SEL;
                end
                S_SEL: begin
                    // k==5 is the extra edge that registers the winner into out_mode.
                    if (k == 3'd5) begin
                        fin       = 1'b1;
                        state_nxt = S_OUT;
                    end else begin
                        sel_en = 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) state_nxt = S_LOAD;
                end
                default: state_nxt = S_LOAD;
            endcase
        end
    end

    always_comb begin
        pa = 3'd0;
        pb = 3'd1;
        case (p)
            4'd0: begin pa = 3'd0; pb = 3'd1; end
            4'd1: begin pa = 3'd0; pb = 3'd2; end
            4'd2: begin pa = 3'd0; pb = 3'd3; end
            4'd3: begin pa = 3'd0; pb = 3'd4; end
            4'd4: begin pa = 3'd1; pb = 3'd2; end
            4'd5: begin pa = 3'd1; pb = 3'd3; end
            4'd6: begin pa = 3'd1; pb = 3'd4; end
            4'd7: begin pa = 3'd2; pb = 3'd3; end
            4'd8: begin pa = 3'd2; pb = 3'd4; end
            4'd9: begin pa = 3'd3; pb = 3'd4; end
            default: begin pa = 3'd0; pb = 3'd1; end
        endcase
    end

    assign pair_eq = (s[pa] == s[pb]);
    assign take_k  = (c[k] > best_cnt) || ((c[k] == best_cnt) && (s[k] > best_val));

    assign in_ready  = (state == S_LOAD);
    assign busy      = (state != S_LOAD);
    assign out_valid = (state == S_OUT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nxt;
    end

    // NOTE: the sample buffer has no reset; each slot is written before the CMP pass reads it.
    always_ff @(posedge clk) begin
        if (accept) s[wr_idx] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= 3'd0;
        end else if (clear) begin
            wr_idx <= 3'd0;
        end else if (accept) begin
            wr_idx <= (wr_idx == 3'd4) ? 3'd0 : wr_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= 4'd0;
            for (int i = 0; i < 5; i++) c[i] <= 3'd1;
        end else if (accept && (wr_idx == 3'd4)) begin
            p <= 4'd0;
            for (int i = 0; i < 5; i++) c[i] <= 3'd1;
        end else if (cmp_en) begin
            p <= p + 4'd1;
            for (int i = 0; i < 5; i++) begin
                if (pair_eq && ((3'(i) == pa) || (3'(i) == pb)) && (c[i] != 3'd5))
                    c[i] <= c[i] + 3'd1;
            end
        end
    end

    // Counts are final for c[0] once pair (0,4) is done, so seeding best from c[0] at p==9 is safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= 3'd0;
            best_val <= '0;
            best_cnt <= 3'd0;
        end else if (cmp_en && (p == 4'd9)) begin
            k        <= 3'd0;
            best_val <= s[0];
            best_cnt <= c[0];
        end else if (sel_en) begin
            k <= k + 3'd1;
            if (take_k) begin
                best_val <= s[k];
                best_cnt <= c[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   out_mode <= '0;
        else if (fin) out_mode <= best_val;
    end

`ifdef MODE_SEQ_CNT_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   out_cnt <= 3'd0;
        else if (fin) out_cnt <= best_cnt;
    end
`else
    // Without the count port, best_cnt only steers the SEL scan.
`endif

endmodule
